// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the accumulator-ALU fetch/decode/execute sequencer.
package alu_seq_pkg;

  localparam int DEF_PC_W     = 8;
  localparam int DEF_DATA_W   = 8;
  localparam int DEF_OPCODE_W = 4;
  localparam int DEF_REG_AW   = 3;
  localparam int DEF_INSTR_W  = 2 + DEF_OPCODE_W + 2 + DEF_DATA_W;

  // Instruction layout, MSB first: kind | opcode/sub-op | reserved | operand
  localparam int KIND_W    = 2;
  localparam int RSVD_W    = 2;
  localparam int OPND_LSB  = 0;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_FETCH    = 3'd1,
    S_DECODE   = 3'd2,
    S_MEM_WAIT = 3'd3,
    S_EXEC     = 3'd4,
    S_HALT     = 3'd5
  } state_t;

  typedef enum logic [1:0] {
    K_REG  = 2'b00,
    K_MEM  = 2'b01,
    K_IMM  = 2'b10,
    K_CTRL = 2'b11
  } kind_t;

  localparam logic [3:0] SUB_NOP  = 4'b0000;
  localparam logic [3:0] SUB_JMP  = 4'b0001;
  localparam logic [3:0] SUB_JC   = 4'b0010;
  localparam logic [3:0] SUB_LDR  = 4'b0011;
  localparam logic [3:0] SUB_HALT = 4'b1111;

  function automatic logic is_legal_sub(input logic [3:0] sub);
    return (sub == SUB_NOP) || (sub == SUB_JMP) || (sub == SUB_JC) ||
           (sub == SUB_LDR) || (sub == SUB_HALT);
  endfunction

endpackage

// File: rtl/alu_seq_decoder.sv
// Combinational decode of registered state and IR fields into ALU control strobes.
module alu_seq_decoder
  import alu_seq_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int OPCODE_W = DEF_OPCODE_W,
  parameter int REG_AW   = DEF_REG_AW
) (
  input  state_t              state,
  input  kind_t               kind,
  input  logic [OPCODE_W-1:0] op,
  input  logic [DATA_W-1:0]   operand,
  output logic [DATA_W-1:0]   data_mem_addr,
  output logic [OPCODE_W-1:0] operation_code,
  output logic                acumulator_ce,
  output logic                register_file_ce,
  output logic [REG_AW-1:0]   register_file_mux_addr,
  output logic                data_memory_read_enable,
  output logic [DATA_W-1:0]   direct_data,
  output logic                direct_load,
  output logic                illegal
);

  always_comb begin
    data_mem_addr           = '0;
    operation_code          = '0;
    acumulator_ce           = 1'b0;
    register_file_ce        = 1'b0;
    register_file_mux_addr  = '0;
    data_memory_read_enable = 1'b0;
    direct_data             = '0;
    direct_load             = 1'b0;
    illegal                 = 1'b0;

    // Memory address is presented a cycle early so synchronous data memory has settled by EXEC.
    if (kind == K_MEM && (state == S_MEM_WAIT || state == S_EXEC))
      data_mem_addr = operand;

    if (state == S_EXEC) begin
      case (kind)
        K_REG: begin
          operation_code         = op;
          register_file_mux_addr = operand[REG_AW-1:0];
          acumulator_ce          = 1'b1;
        end
        K_MEM: begin
          operation_code          = op;
          data_memory_read_enable = 1'b1;
          acumulator_ce           = 1'b1;
        end
        K_IMM: begin
          operation_code = op;
          direct_data    = operand;
          direct_load    = 1'b1;
          acumulator_ce  = 1'b1;
        end
        K_CTRL: begin
          if (op[3:0] == SUB_LDR) begin
            register_file_ce       = 1'b1;
            register_file_mux_addr = operand[REG_AW-1:0];
          end
          illegal = !is_legal_sub(op[3:0]);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/alu_sequencer.sv
// Fetch/decode/execute controller driving the accumulator ALU from a synchronous program memory.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   IDLE     | after reset; waits for i_start, restarts program at PC=0
//   FETCH    | program memory read at PC
//   DECODE   | instruction word arrives, latched into IR
//   MEM_WAIT | data memory address presented, read data settling
//   EXEC     | one-cycle strobe to the ALU / control-flow update of PC
//   HALT     | stopped after HALT; i_start resumes at the next PC
module alu_sequencer
  import alu_seq_pkg::*;
#(
  parameter int PC_W     = DEF_PC_W,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int OPCODE_W = DEF_OPCODE_W,
  parameter int REG_AW   = DEF_REG_AW,
  parameter int INSTR_W  = 2 + OPCODE_W + 2 + DATA_W
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_start,
  output logic [PC_W-1:0]     o_pc,
  output logic                o_prog_rd_en,
  input  logic [INSTR_W-1:0]  i_instr,
  output logic [DATA_W-1:0]   o_data_mem_addr,
  output logic [OPCODE_W-1:0] o_operation_code,
  output logic                o_acumulator_ce,
  output logic                o_register_file_ce,
  output logic [REG_AW-1:0]   o_register_file_mux_addr,
  output logic                o_data_memory_read_enable,
  output logic [DATA_W-1:0]   o_direct_data,
  output logic                o_direct_load,
  input  logic                i_carry,
  output logic                o_busy,
  output logic                o_halted,
  output logic                o_illegal
);

  localparam int KIND_LSB = INSTR_W - KIND_W;
  localparam int OP_LSB   = KIND_LSB - OPCODE_W;
  localparam int RSVD_LSB = OP_LSB - RSVD_W;

  state_t               state, state_nxt;
  logic [PC_W-1:0]      pc, pc_nxt;
  logic [INSTR_W-1:0]   ir, ir_nxt;
  logic                 carry_q, carry_nxt;

  kind_t                ir_kind;
  logic [OPCODE_W-1:0]  ir_op;
  logic [DATA_W-1:0]    ir_operand;
  kind_t                instr_kind;
  logic                 acc_ce;
  logic                 unused_rsvd;

  assign ir_kind     = kind_t'(ir[INSTR_W-1 -: KIND_W]);
  assign ir_op       = ir[OP_LSB +: OPCODE_W];
  assign ir_operand  = ir[OPND_LSB +: DATA_W];
  assign instr_kind  = kind_t'(i_instr[INSTR_W-1 -: KIND_W]);
  assign unused_rsvd = ^{ir[RSVD_LSB +: RSVD_W], i_instr[OP_LSB-1:0]};

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state   <= S_IDLE;
      pc      <= '0;
      ir      <= '0;
      carry_q <= 1'b0;
    end else begin
      state   <= state_nxt;
      pc      <= pc_nxt;
      ir      <= ir_nxt;
      carry_q <= carry_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    ir_nxt    = ir;
    carry_nxt = carry_q;

    case (state)
      S_IDLE: begin
        if (i_start) begin
          state_nxt = S_FETCH;
          pc_nxt    = '0;
        end
      end
      S_HALT: begin
        if (i_start)
          state_nxt = S_FETCH;
      end
      S_FETCH: state_nxt = S_DECODE;
      S_DECODE: begin
        ir_nxt    = i_instr;
        state_nxt = (instr_kind == K_MEM) ? S_MEM_WAIT : S_EXEC;
      end
      S_MEM_WAIT: state_nxt = S_EXEC;
      S_EXEC: begin
        state_nxt = S_FETCH;
        pc_nxt    = pc + PC_W'(1);
        if (acc_ce)
          carry_nxt = i_carry;
        if (ir_kind == K_CTRL) begin
          case (ir_op[3:0])
            SUB_JMP:  pc_nxt = ir_operand[PC_W-1:0];
            SUB_JC:   if (carry_q) pc_nxt = ir_operand[PC_W-1:0];
            SUB_HALT: state_nxt = S_HALT;
            default: ;
          endcase
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  alu_seq_decoder #(
    .DATA_W   (DATA_W),
    .OPCODE_W (OPCODE_W),
    .REG_AW   (REG_AW)
  ) u_decoder (
    .state                   (state),
    .kind                    (ir_kind),
    .op                      (ir_op),
    .operand                 (ir_operand),
    .data_mem_addr           (o_data_mem_addr),
    .operation_code          (o_operation_code),
    .acumulator_ce           (acc_ce),
    .register_file_ce        (o_register_file_ce),
    .register_file_mux_addr  (o_register_file_mux_addr),
    .data_memory_read_enable (o_data_memory_read_enable),
    .direct_data             (o_direct_data),
    .direct_load             (o_direct_load),
    .illegal                 (o_illegal)
  );

  assign o_acumulator_ce = acc_ce;
  assign o_pc            = pc;
  assign o_prog_rd_en    = (state == S_FETCH);
  assign o_busy          = (state != S_IDLE) && (state != S_HALT);
  assign o_halted        = (state == S_HALT);

endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
- Fetch/decode/execute controller that drives the control inputs of the accumulator ALU: opcode, accumulator CE, register-file CE and mux address, data-memory select and direct-load select.
- Reads instructions from a synchronous program memory and sequences one ALU operation per instruction.
- Issues data-memory addresses and handles jumps, carry-conditional jumps and halt.
- Sits between the program/data memories and the ALU datapath.

Parameters:
- PC_W, 8, program counter / program memory address width
- DATA_W, 8, ALU data width; also the immediate and memory-address width
- OPCODE_W, 4, ALU operation code width
- REG_AW, 3, register file address width
- INSTR_W, 16, instruction width; fixed at 2+OPCODE_W+2+DATA_W

Ports:
- i_clk  in  1  clock, rising edge
- i_rst_n  in  1  asynchronous active-low reset
- i_start  in  1  start pulse; honoured only in IDLE or HALT
- o_pc  out  PC_W  program memory address
- o_prog_rd_en  out  1  program memory read strobe
- i_instr  in  INSTR_W  program memory data, valid 1 cycle after o_prog_rd_en
- o_data_mem_addr  out  DATA_W  data memory address
- o_operation_code  out  OPCODE_W  ALU opcode
- o_acumulator_ce  out  1  accumulator load enable
- o_register_file_ce  out  1  register file write enable
- o_register_file_mux_addr  out  REG_AW  register select
- o_data_memory_read_enable  out  1  selects data memory as ALU argument
- o_direct_data  out  DATA_W  immediate operand
- o_direct_load  out  1  selects immediate as ALU argument
- i_carry  in  1  ALU carry out
- o_busy  out  1  high outside IDLE/HALT
- o_halted  out  1  high in HALT
- o_illegal  out  1  one-cycle pulse on an undefined control sub-op

Behaviour:
- Reset (asynchronous, any state):
  - state=IDLE, PC=0, IR=0, carry_q=0.
  - All outputs 0.
- Outputs are decoded only from registered state, IR and PC. There is no combinational input-to-output path.
- Instruction fields:
  - [15:14] kind: 00 reg-source ALU op, 01 memory-source ALU op, 10 immediate ALU op, 11 control.
  - [13:10] ALU opcode, or control sub-op when kind=11.
  - [9:8] reserved, ignored.
  - [7:0] operand: register index (low REG_AW bits), memory address, immediate, or jump target.
- States: IDLE, FETCH, DECODE, MEM_WAIT, EXEC, HALT.
- IDLE/HALT -> FETCH on i_start. PC=0 from IDLE; from HALT, PC keeps the value following the HALT instruction.
- FETCH: o_prog_rd_en=1, o_pc=PC -> DECODE.
- DECODE: IR<=i_instr.
  - kind 01 -> MEM_WAIT.
  - All other kinds -> EXEC.
- MEM_WAIT: o_data_mem_addr=IR operand, held through EXEC -> EXEC.
- EXEC, one cycle; strobes are high for exactly this cycle:
  - kind 00: opcode=IR op, o_register_file_mux_addr=operand, o_acumulator_ce=1.
  - kind 01: opcode=IR op, o_data_memory_read_enable=1, o_acumulator_ce=1.
  - kind 10: opcode=IR op, o_direct_data=operand, o_direct_load=1, o_acumulator_ce=1.
  - carry_q<=i_carry whenever o_acumulator_ce=1.
  - kind 11 sub-ops:
    - 0000 NOP.
    - 0001 JMP: PC<=operand[PC_W-1:0].
    - 0010 JC: PC<=operand if carry_q, else PC+1.
    - 0011 LDR: o_register_file_ce=1, mux addr=operand.
    - 1111 HALT: -> HALT, PC<=PC+1.
    - Any other sub-op: treated as NOP, o_illegal=1.
- EXEC -> FETCH, except after HALT. PC<=PC+1 unless the jump is taken.
- Latency: 3 cycles per instruction; 4 cycles for memory-source ops.
- PC wraps from 2^PC_W-1 to 0 silently.
- i_start outside IDLE/HALT is ignored.
- Reset mid-instruction aborts it with no strobe completion.

Decomposition:
- Package alu_seq_pkg:
  - State enum.
  - Kind enum.
  - Control sub-op constants: NOP, JMP, JC, LDR, HALT.
  - Instruction field bit positions.
  - Width localparams.
- Optional sub-module alu_seq_decoder: combinational IR+state -> strobe/opcode outputs. The FSM, PC and carry_q stay in the top module.

Test Plan:
- Reset during EXEC of an immediate op -> all outputs 0 within the same cycle; state IDLE; PC=0; o_busy=0.
- prog[0]=0x842A (kind10, op1, imm 0x2A), pulse i_start:
  - 3rd cycle after start: o_direct_load=1, o_direct_data=0x2A, o_operation_code=1, o_acumulator_ce=1, each for exactly 1 cycle.
  - Next fetch uses o_pc=1.
- prog[0]=0x4810 (kind01, op2, addr 0x10):
  - o_data_mem_addr=0x10 from the MEM_WAIT cycle.
  - o_data_memory_read_enable=1 with o_acumulator_ce=1 on the 4th cycle.
- JC 0x20 after an ALU op with i_carry=1 -> next o_pc=0x20. Repeat with i_carry=0 -> next o_pc=PC+1.
- Control word 0xD400 (kind11, sub-op 0101, undefined) -> o_illegal pulses 1 cycle and execution continues.
- HALT at PC=0x05 -> o_halted=1, o_busy=0. A later i_start resumes fetching at 0x06.
- JMP 0xFF, then an immediate op at 0xFF -> the following fetch is at o_pc=0x00 (wrap).
